// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: merges CHANNELS valid/ready producer streams into one registered consumer stream.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle while out_ready is high.
// Backpressure: a full stage with out_ready low holds its beat and drops every in_ready.
// Optional round-robin arbitration is compiled in with `define MUX_RR_EN (mode honoured only then).
module mux_nto1_stream #(
  parameter int  WIDTH    = 8,
  parameter int  CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          select,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;

  logic [WIDTH-1:0] data_d;    // data of the granted channel
  logic [SEL_W-1:0] chan_d;    // granted channel index
  logic             grant_ok;  // a legal grant exists this cycle
  logic             valid_g;   // in_valid of the granted channel
  logic             can_load;  // stage is empty or draining this cycle
  logic             xfer;      // a beat moves from the granted channel into the stage

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_q;  // last channel granted in round-robin mode

  // Grant: round-robin search starting after rr_ptr, otherwise the fixed select.
  always_comb begin
    logic [SEL_W:0] sum;
    chan_d   = '0;
    grant_ok = 1'b0;
    sum      = '0;
    if (mode) begin
      for (int k = 1; k <= CHANNELS; k++) begin
        sum = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
        if (sum >= (SEL_W+1)'(CHANNELS)) begin
          sum = sum - (SEL_W+1)'(CHANNELS);
        end
        if (!grant_ok && in_valid[sum[SEL_W-1:0]]) begin
          grant_ok = 1'b1;
          chan_d   = sum[SEL_W-1:0];
        end
      end
    end else begin
      chan_d   = select;
      grant_ok = int'(select) < CHANNELS;
    end
  end

  // Pointer remembers the last round-robin winner; reset gives channel 0 first priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= SEL_W'(CHANNELS - 1);
    end else if (xfer && mode) begin
      rr_ptr_q <= chan_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  // Grant: fixed select only; an out-of-range index grants nothing.
  always_comb begin
    chan_d   = select;
    grant_ok = int'(select) < CHANNELS;
  end
`endif

  // Pick data and valid of the granted channel without indexing past the last channel.
  always_comb begin
    data_d  = '0;
    valid_g = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (chan_d == SEL_W'(i)) begin
        data_d  = in_data[i*WIDTH +: WIDTH];
        valid_g = in_valid[i];
      end
    end
  end

  assign can_load = (state_q == EMPTY) || out_ready;
  assign xfer     = !reset && can_load && grant_ok && valid_g;

  // One-hot accept toward the granted producer; forced low while reset is held.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = xfer && (chan_d == SEL_W'(i));
    end
  end

  // Output stage: load on transfer (also when draining), empty on drain without a new beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
      chan_q  <= '0;
    end else if (can_load) begin
      if (xfer) begin
        state_q <= FULL;
        data_q  <= data_d;
        chan_q  <= chan_d;
      end else begin
        state_q <= EMPTY;
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Testbench for mux_nto1_stream: directed scenarios plus randomized traffic against a reference model.
// Main instance has 4 channels; a 3-channel instance covers the out-of-range select.
// Round-robin scenarios are built only when MUX_RR_EN is defined.
module tb_mux_nto1_stream;

`ifdef MUX_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_ready;
  logic [1:0]  select = '0;
  logic        mode = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  out_chan;
  logic        out_ready = 1'b0;

  logic [23:0] in_data3 = '0;
  logic [2:0]  in_valid3 = '0;
  logic [2:0]  in_ready3;
  logic [1:0]  select3 = '0;
  logic        mode3 = 1'b0;
  logic [7:0]  out_data3;
  logic        out_valid3;
  logic [1:0]  out_chan3;
  logic        out_ready3 = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model of the output register and round-robin pointer
  bit         m_vld = 1'b0;
  logic [7:0] m_dat = '0;
  int         m_chan = 0;
  int         m_ptr = 3;

  always #5 clk = ~clk;

  mux_nto1_stream #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .mode(mode), .out_data(out_data), .out_valid(out_valid),
    .out_chan(out_chan), .out_ready(out_ready)
  );

  mux_nto1_stream #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .select(select3), .mode(mode3), .out_data(out_data3), .out_valid(out_valid3),
    .out_chan(out_chan3), .out_ready(out_ready3)
  );

  // Channel that would be granted, or -1 when no grant is possible
  function automatic int ref_grant();
    if (RR_ON && mode) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    if (int'(select) < 4) return int'(select);
    return -1;
  endfunction

  function automatic logic [3:0] ref_ready();
    int g;
    logic [3:0] r;
    r = '0;
    if (reset) return r;
    g = ref_grant();
    if ((!m_vld || out_ready) && g >= 0 && in_valid[g]) r[g] = 1'b1;
    return r;
  endfunction

  // Update the model for the coming edge, then move to just after it
  task automatic advance();
    int g;
    g = ref_grant();
    if (reset) begin
      m_vld = 1'b0; m_dat = '0; m_chan = 0; m_ptr = 3;
    end else if (!m_vld || out_ready) begin
      if (g >= 0 && in_valid[g]) begin
        m_vld  = 1'b1;
        m_dat  = in_data[g*8 +: 8];
        m_chan = g;
        if (RR_ON && mode) m_ptr = g;
      end else begin
        m_vld = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    m_vld = 1'b0; m_dat = '0; m_chan = 0; m_ptr = 3;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 4'b1111; in_data = 32'hDEADBEEF; select = 2'd0; out_ready = 1'b1;
    in_valid3 = 3'b111; select3 = 2'd0; out_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    n_chk++; if (out_chan !== 2'd0) begin n_fail++; $display("FAIL reset_out_chan: got %0d expected 0", out_chan); end
    n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready); end
    n_chk++; if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL reset_in_ready3: got %b expected 000", in_ready3); end
    reset = 1'b0;
    in_valid3 = 3'b000;
  endtask

  task automatic test_fixed_basic();
    select = 2'd2; in_data = 32'h00A50000; in_valid = 4'b0100; out_ready = 1'b1; mode = 1'b0;
    #1;
    n_chk++; if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_in_ready: got %b expected 0100", in_ready); end
    advance();
    n_chk++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL fixed_out_data: got %h expected a5", out_data); end
    n_chk++; if (out_chan !== 2'd2) begin n_fail++; $display("FAIL fixed_out_chan: got %0d expected 2", out_chan); end
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_out_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_backpressure();
    select = 2'd0; in_data = 32'h00002211; in_valid = 4'b0001; out_ready = 1'b1;
    advance();
    n_chk++; if (out_data !== 8'h11) begin n_fail++; $display("FAIL bp_load: got %h expected 11", out_data); end
    out_ready = 1'b0; select = 2'd1; in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready); end
      advance();
      n_chk++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got data %h valid %b expected 11/1", i, out_data, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    n_chk++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 0010", in_ready); end
    advance();
    n_chk++; if (out_data !== 8'h22 || out_chan !== 2'd1) begin
      n_fail++; $display("FAIL bp_release_beat: got data %h chan %0d expected 22/1", out_data, out_chan);
    end
    in_valid = 4'b0000;
    advance();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_out_of_range();
    select3 = 2'd0; in_data3 = 24'h332211; in_valid3 = 3'b111; out_ready3 = 1'b1;
    advance();
    n_chk++; if (out_valid3 !== 1'b1 || out_data3 !== 8'h11 || out_chan3 !== 2'd0) begin
      n_fail++; $display("FAIL oor_load: got valid %b data %h chan %0d expected 1/11/0", out_valid3, out_data3, out_chan3);
    end
    select3 = 2'd3;
    #1;
    n_chk++; if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL oor_in_ready: got %b expected 000", in_ready3); end
    advance();
    n_chk++; if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL oor_drain: got %b expected 0", out_valid3); end
    advance();
    n_chk++; if (out_valid3 !== 1'b0 || in_ready3 !== 3'b000) begin
      n_fail++; $display("FAIL oor_stay_empty: got valid %b ready %b expected 0/000", out_valid3, in_ready3);
    end
    in_valid3 = 3'b000;
  endtask

`ifdef MUX_RR_EN
  task automatic test_rr_all();
    pulse_reset();
    mode = 1'b1; in_valid = 4'b1111; in_data = 32'h03020100; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_chk++; if (in_ready !== 4'(1 << (i % 4))) begin
        n_fail++; $display("FAIL rr_all_ready[%0d]: got %b expected %b", i, in_ready, 4'(1 << (i % 4)));
      end
      advance();
      n_chk++; if (out_valid !== 1'b1 || int'(out_chan) != i % 4 || int'(out_data) != i % 4) begin
        n_fail++; $display("FAIL rr_all_beat[%0d]: got valid %b chan %0d data %h expected 1/%0d", i, out_valid, out_chan, out_data, i % 4);
      end
    end
  endtask

  task automatic test_rr_sparse_reset();
    int exp_c;
    pulse_reset();
    mode = 1'b1; in_data = 32'h33221100; in_valid = 4'b0010; out_ready = 1'b1;
    advance();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0) ? 3 : 1;
      advance();
      n_chk++; if (int'(out_chan) != exp_c || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL rr_sparse[%0d]: got chan %0d valid %b expected %0d/1", i, out_chan, out_valid, exp_c);
      end
    end
    reset = 1'b1;
    m_vld = 1'b0; m_dat = '0; m_chan = 0; m_ptr = 3;
    #1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      n_fail++; $display("FAIL rr_midreset: got valid %b ready %b expected 0/0000", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_chk++; if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL rr_post_reset_ready: got %b expected 0010", in_ready); end
    advance();
    n_chk++; if (out_chan !== 2'd1) begin n_fail++; $display("FAIL rr_post_reset_chan: got %0d expected 1", out_chan); end
  endtask
`endif

  task automatic test_random();
    logic [3:0] exp_r;
    for (int n = 0; n < 400; n++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      select    = 2'($urandom_range(0, 3));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_r = ref_ready();
      n_chk++; if (in_ready !== exp_r) begin
        n_fail++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", n, in_ready, exp_r);
      end
      advance();
      n_chk++; if (out_valid !== m_vld || out_data !== m_dat || int'(out_chan) != m_chan) begin
        n_fail++; $display("FAIL rand_out[%0d]: got %b/%h/%0d expected %b/%h/%0d", n, out_valid, out_data, out_chan, m_vld, m_dat, m_chan);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_basic();
    test_backpressure();
    test_out_of_range();
`ifdef MUX_RR_EN
    test_rr_all();
    test_rr_sparse_reset();
`endif
    pulse_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
